delay_hs_arr: RTL and testbench
===============================

Name: delay_hs_arr

Overview:
- Handshaked counterpart of the free-running delay array: a DELAY-stage, WIDTH-bit pipeline with a valid/ready interface on both ends.
- The consumer end drives backpressure, so words stall in place and bubbles collapse instead of being overwritten.
- Sits between pipeline producers and a stallable consumer stage, e.g. a memory or writeback unit that cannot always accept.

Parameters:
- WIDTH, 4, data word width in bits
- DELAY, 2, number of register stages; legal range DELAY >= 1

Ports:
- ctrl  input  Data_Control_T  control bundle; the Data_Control_Clock field is the single clock (rising edge); the Data_Control_Reset field is the reset, asynchronous and active-high
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  producer presents a word
- in_ready  output  1  stage 0 can accept this cycle
- in  input  WIDTH  producer word
- out_valid  output  1  last stage holds a word
- out_ready  input  1  consumer accepts this cycle
- out  output  WIDTH  last-stage word
- count  output  $clog2(DELAY+1)  number of valid stages

Behaviour:
- State per stage k (0..DELAY-1): data[k] (WIDTH bits) and valid[k]. out = data[DELAY-1]; out_valid = valid[DELAY-1].
- Reset asserted (asynchronous):
  - all data = 0, all valid = 0, so out = 0, out_valid = 0, count = 0.
  - in_ready = 1 if flush = 0.
  - Reset mid-transfer discards every word in flight.
- Combinational move terms:
  - leave[DELAY-1] = valid[DELAY-1] & out_ready
  - open[k] = !valid[k] | leave[k]
  - leave[k] = valid[k] & open[k+1], for k < DELAY-1
  - in_ready = open[0] & !flush
- Rising edge, flush = 0:
  - stage k+1 loads data[k] and valid = 1 when leave[k].
  - stage 0 loads in when in_valid & in_ready.
  - A stage that emptied and received nothing: valid = 0, data retained.
  - A stage with valid = 1 and !leave holds both data and valid.
- Rising edge, flush = 1: all valid = 0, all data = 0. The input word is not accepted (in_ready = 0). Any word shown on out that cycle counts as not transferred, even if out_ready = 1.
- Throughput and latency: with out_ready held high, one word per cycle, zero bubbles. A word accepted at edge t is on out after edge t+DELAY-1, which is DELAY edges of residence counting the capture edge.
- Bubble collapse: a word advances whenever the next stage is empty or emptying, regardless of out_ready.
- Full pipe (all valid) with out_ready = 0: in_ready = 0, contents frozen.
- Full pipe with out_ready = 1: in_ready = 1. Simultaneous pop and push keeps count at DELAY.
- count: popcount of valid[]; updates on the same edge as the stages. Never exceeds DELAY; never wraps.
- Producer rules: in may change freely while in_valid = 0. A word is transferred only on an edge where in_valid & in_ready.
- No combinational path from in_valid to in_ready.
- out_ready-to-in_ready combinational path is allowed and required for full throughput.
- DELAY = 1: single stage; in_ready = !valid[0] | out_ready.

Test Plan:
- Reset: assert reset 4 ns with in_valid = 1, in = 4'h7 -> out = 0, out_valid = 0, count = 0 throughout; no capture while reset is high.
- Streaming (WIDTH = 4, DELAY = 2): out_ready = 1, in = 1,2,3,... one per cycle after reset release -> out_valid rises 2 edges after the first accept; out sequence 1,2,3,... with no gaps; count = 2 in steady state.
- Backpressure: fill with 5, 6, then out_ready = 0 for 3 cycles with in_valid = 1, in = 9 -> in_ready = 0, count = 2, out = 5 held. Release out_ready -> outputs 5, 6, 9 in order; 9 is accepted on the release cycle.
- Bubble collapse: accept only 3 with out_ready = 0 -> after 2 edges valid = {1,0} (stage 1 holds 3), in_ready = 1. Accept 4 -> count = 2, in_ready = 0.
- Flush: pipe holding 3, 4; flush = 1 for one cycle with in_valid = 1, in = 8, out_ready = 1 -> next cycle count = 0, out_valid = 0, out = 0. The 8 never appears on out.
- Full pop/push: DELAY = 1 build, valid word A, out_ready = 1, in_valid = 1, in = B -> after edge out = B, out_valid = 1, count = 1.

Source files
------------

// File: rtl/delay_hs_arr.sv
// Handshaked delay array: DELAY-stage, WIDTH-bit pipeline with valid/ready on both ends.
// Words stall under backpressure and bubbles collapse toward the output.

package delay_hs_arr_pkg;
    typedef struct packed {
        logic Data_Control_Clock;
        logic Data_Control_Reset;
    } Data_Control_T;
endpackage

module delay_hs_arr
    import delay_hs_arr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DELAY = 2
) (
    input  delay_hs_arr_pkg::Data_Control_T    ctrl,
    input  logic                               flush,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out,
    output logic [$clog2(DELAY+1)-1:0]         count
);

    localparam int CNT_W = $clog2(DELAY + 1);

    logic clk;
    logic rst;

    logic [WIDTH-1:0] data [DELAY];
    logic [DELAY-1:0] valid;
    logic [DELAY-1:0] leave;
    logic [DELAY-1:0] can_take;

    assign clk = ctrl.Data_Control_Clock;
    assign rst = ctrl.Data_Control_Reset;

    // Walk from the output back to stage 0 so each stage sees whether its
    // downstream neighbour is empty or emptying this cycle.
    always_comb begin
        logic downstream_open;
        downstream_open = out_ready;
        leave           = '0;
        can_take        = '0;
        for (int k = DELAY - 1; k >= 0; k--) begin
            leave[k]        = valid[k] & downstream_open;
            can_take[k]     = ~valid[k] | leave[k];
            downstream_open = can_take[k];
        end
    end

    assign in_ready  = can_take[0] & ~flush;
    assign out_valid = valid[DELAY-1];
    assign out       = data[DELAY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int k = 0; k < DELAY; k++) begin
                data[k] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
            for (int k = 0; k < DELAY; k++) begin
                data[k] <= '0;
            end
        end else begin
            if (in_valid && in_ready) begin
                data[0]  <= in;
                valid[0] <= 1'b1;
            end else if (leave[0]) begin
                valid[0] <= 1'b0;
            end
            // An emptied stage keeps its stale data; only valid drops.
            for (int k = 1; k < DELAY; k++) begin
                if (leave[k-1]) begin
                    data[k]  <= data[k-1];
                    valid[k] <= 1'b1;
                end else if (leave[k]) begin
                    valid[k] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] sum;
        sum = '0;
        for (int k = 0; k < DELAY; k++) begin
            sum = sum + CNT_W'(valid[k]);
        end
        count = sum;
    end

endmodule

// File: tb/tb_delay_hs_arr.sv
// Self-checking bench for delay_hs_arr: directed vector tables for DELAY=2 and DELAY=1,
// plus randomized traffic against a queue-of-words reference model.

module tb_delay_hs_arr;
    import delay_hs_arr_pkg::*;

    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    Data_Control_T ctrl;
    assign ctrl.Data_Control_Clock = clk;
    assign ctrl.Data_Control_Reset = rst;

    logic       flush2 = 0, in_valid2 = 0, out_ready2 = 0;
    logic [3:0] in2 = 0;
    logic       in_ready2, out_valid2;
    logic [3:0] out2;
    logic [1:0] count2;

    logic       flush1 = 0, in_valid1 = 0, out_ready1 = 0;
    logic [3:0] in1 = 0;
    logic       in_ready1, out_valid1;
    logic [3:0] out1;
    logic [0:0] count1;

    delay_hs_arr #(.WIDTH(4), .DELAY(2)) dut2 (
        .ctrl(ctrl), .flush(flush2), .in_valid(in_valid2), .in_ready(in_ready2),
        .in(in2), .out_valid(out_valid2), .out_ready(out_ready2), .out(out2), .count(count2)
    );

    delay_hs_arr #(.WIDTH(4), .DELAY(1)) dut1 (
        .ctrl(ctrl), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in(in1), .out_valid(out_valid1), .out_ready(out_ready1), .out(out1), .count(count1)
    );

    typedef struct {
        logic       flush;
        logic       in_valid;
        logic [3:0] din;
        logic       out_ready;
        logic       exp_ov;
        logic [3:0] exp_out;
        int         exp_cnt;
        logic       exp_ir;
    } vec_t;

    typedef struct {
        logic [3:0] word;
        int         pos;
    } ent_t;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: words in flight, oldest first, each with its stage index.
    ent_t       mq[$];
    logic [3:0] m_last = 4'h0;

    vec_t tbl2[21];
    vec_t tbl1[6];

    task automatic check_output(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_in_ready(input logic fl, input logic ordy);
        int limit;
        int np;
        if (fl) return 1'b0;
        limit = D2;
        foreach (mq[i]) begin
            if (mq[i].pos == D2 - 1) np = ordy ? D2 : D2 - 1;
            else np = (mq[i].pos + 1 < limit) ? mq[i].pos + 1 : mq[i].pos;
            limit = np;
        end
        return limit > 0;
    endfunction

    task automatic model_edge(input logic fl, input logic iv, input logic [3:0] din, input logic ordy);
        int   limit;
        int   np;
        bit   acc;
        ent_t nq[$];
        if (fl) begin
            mq.delete();
            m_last = 4'h0;
            return;
        end
        acc   = iv && model_in_ready(1'b0, ordy);
        limit = D2;
        foreach (mq[i]) begin
            if (mq[i].pos == D2 - 1) np = ordy ? D2 : D2 - 1;
            else np = (mq[i].pos + 1 < limit) ? mq[i].pos + 1 : mq[i].pos;
            limit = np;
            if (np < D2) begin
                if (np == D2 - 1 && mq[i].pos != D2 - 1) m_last = mq[i].word;
                nq.push_back('{word: mq[i].word, pos: np});
            end
        end
        if (acc) nq.push_back('{word: din, pos: 0});
        mq = nq;
    endtask

    task automatic apply_stimulus2(input vec_t v, input string tag);
        flush2 = v.flush; in_valid2 = v.in_valid; in2 = v.din; out_ready2 = v.out_ready;
        #1;
        check_output({tag, ".out_valid"}, int'(out_valid2), int'(v.exp_ov));
        check_output({tag, ".out"}, int'(out2), int'(v.exp_out));
        check_output({tag, ".count"}, int'(count2), v.exp_cnt);
        check_output({tag, ".in_ready"}, int'(in_ready2), int'(v.exp_ir));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus1(input vec_t v, input string tag);
        flush1 = v.flush; in_valid1 = v.in_valid; in1 = v.din; out_ready1 = v.out_ready;
        #1;
        check_output({tag, ".out_valid"}, int'(out_valid1), int'(v.exp_ov));
        check_output({tag, ".out"}, int'(out1), int'(v.exp_out));
        check_output({tag, ".count"}, int'(count1), v.exp_cnt);
        check_output({tag, ".in_ready"}, int'(in_ready1), int'(v.exp_ir));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Fields: flush, in_valid, in, out_ready | out_valid, out, count, in_ready (before the edge)
        tbl2[0]  = '{0, 1, 4'h1, 1, 0, 4'h0, 0, 1};
        tbl2[1]  = '{0, 1, 4'h2, 1, 0, 4'h0, 1, 1};
        tbl2[2]  = '{0, 1, 4'h3, 1, 1, 4'h1, 2, 1};
        tbl2[3]  = '{0, 0, 4'h0, 1, 1, 4'h2, 2, 1};
        tbl2[4]  = '{0, 0, 4'h0, 1, 1, 4'h3, 1, 1};
        tbl2[5]  = '{0, 1, 4'h5, 1, 0, 4'h3, 0, 1};
        tbl2[6]  = '{0, 1, 4'h6, 0, 0, 4'h3, 1, 1};
        tbl2[7]  = '{0, 1, 4'h9, 0, 1, 4'h5, 2, 0};
        tbl2[8]  = '{0, 1, 4'h9, 0, 1, 4'h5, 2, 0};
        tbl2[9]  = '{0, 1, 4'h9, 0, 1, 4'h5, 2, 0};
        tbl2[10] = '{0, 1, 4'h9, 1, 1, 4'h5, 2, 1};
        tbl2[11] = '{0, 0, 4'h0, 1, 1, 4'h6, 2, 1};
        tbl2[12] = '{0, 0, 4'h0, 1, 1, 4'h9, 1, 1};
        tbl2[13] = '{0, 1, 4'h3, 0, 0, 4'h9, 0, 1};
        tbl2[14] = '{0, 0, 4'h0, 0, 0, 4'h9, 1, 1};
        tbl2[15] = '{0, 1, 4'h4, 0, 1, 4'h3, 1, 1};
        tbl2[16] = '{0, 0, 4'h0, 0, 1, 4'h3, 2, 0};
        tbl2[17] = '{1, 1, 4'h8, 1, 1, 4'h3, 2, 0};
        tbl2[18] = '{0, 0, 4'h0, 1, 0, 4'h0, 0, 1};
        tbl2[19] = '{1, 0, 4'h0, 0, 0, 4'h0, 0, 0};
        tbl2[20] = '{0, 0, 4'h0, 0, 0, 4'h0, 0, 1};

        tbl1[0] = '{0, 1, 4'hA, 1, 0, 4'h0, 0, 1};
        tbl1[1] = '{0, 1, 4'hB, 1, 1, 4'hA, 1, 1};
        tbl1[2] = '{0, 1, 4'hC, 0, 1, 4'hB, 1, 0};
        tbl1[3] = '{0, 0, 4'h0, 0, 1, 4'hB, 1, 0};
        tbl1[4] = '{0, 0, 4'h0, 1, 1, 4'hB, 1, 1};
        tbl1[5] = '{0, 0, 4'h0, 0, 0, 4'hB, 0, 1};

        // Reset held across edges with a word offered: nothing may be captured.
        in_valid2 = 1; in2 = 4'h7; out_ready2 = 1;
        in_valid1 = 1; in1 = 4'h7; out_ready1 = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_output("rst.out_valid", int'(out_valid2), 0);
            check_output("rst.out", int'(out2), 0);
            check_output("rst.count", int'(count2), 0);
            check_output("rst.in_ready", int'(in_ready2), 1);
            check_output("rst.d1.count", int'(count1), 0);
            @(posedge clk);
            #2;
            check_output("rst.post_edge.count", int'(count2), 0);
            check_output("rst.post_edge.out_valid", int'(out_valid2), 0);
        end
        @(negedge clk);
        in_valid1 = 0; in1 = 4'h0;
        rst = 0;

        for (int i = 0; i < 21; i++) apply_stimulus2(tbl2[i], $sformatf("d2.row%0d", i));
        for (int i = 0; i < 6; i++)  apply_stimulus1(tbl1[i], $sformatf("d1.row%0d", i));

        // Randomized traffic on the DELAY=2 instance; the pipe is empty with out=0 here.
        mq.delete();
        m_last = 4'h0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       exp_ov;
            logic [3:0] exp_out;
            flush2     = ($urandom_range(19) == 0);
            in_valid2  = ($urandom_range(3) != 0);
            in2        = 4'($urandom);
            out_ready2 = ($urandom_range(9) < 6);
            #1;
            exp_ov = 1'b0;
            if (mq.size() > 0) exp_ov = (mq[0].pos == D2 - 1);
            exp_out = m_last;
            check_output("rand.out_valid", int'(out_valid2), int'(exp_ov));
            check_output("rand.out", int'(out2), int'(exp_out));
            check_output("rand.count", int'(count2), mq.size());
            check_output("rand.in_ready", int'(in_ready2), int'(model_in_ready(flush2, out_ready2)));
            @(posedge clk);
            model_edge(flush2, in_valid2, in2, out_ready2);
            @(negedge clk);
        end

        // Fill the pipe, then reset asynchronously mid-cycle: words in flight are lost.
        flush2 = 0; in_valid2 = 1; in2 = 4'hE; out_ready2 = 0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check_output("midrst.pre.count", int'(count2), 2);
        #2;
        rst = 1;
        #1;
        check_output("midrst.out_valid", int'(out_valid2), 0);
        check_output("midrst.out", int'(out2), 0);
        check_output("midrst.count", int'(count2), 0);
        check_output("midrst.in_ready", int'(in_ready2), 1);
        @(posedge clk);
        #1;
        check_output("midrst.no_capture", int'(count2), 0);
        @(negedge clk);
        rst = 0;
        in_valid2 = 0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
